audio_stream_i2s_tx: RTL and testbench
======================================

Name: audio_stream_i2s_tx

Overview:
Downstream consumer of the QSYS audio FIFO stream (fifo_0_out_valid/data/ready). Accepts one stereo frame per word and applies the volume setting (vol_ctrl_0 export, 7-bit) with saturation. Serialises the result as an I2S master (BCLK, DACLRCK, DACDAT) to the board audio codec DAC. Counts underflows when the FIFO cannot keep up.

Parameters:
BCLK_HALF_DIV, 8, clk_50 cycles per BCLK half-period (BCLK = clk_50 / (2*BCLK_HALF_DIV)); legal range 2..255.
UNDERFLOW_CNT_W, 16, width of the saturating underflow counter.

Ports:
clk_50  in  1  system clock, the only clock.
reset  in  1  synchronous, active-high reset.
enable  in  1  run request; sampled only at frame boundaries while running.
vol  in  7  unsigned gain; 64 = unity; 0 = silence.
mute  in  1  forces output samples to 0; latched with vol.
in_valid  in  1  stream valid (from fifo_0_out_valid).
in_data  in  32  [31:16] left, [15:0] right; signed two's complement.
in_ready  out  1  stream ready (to fifo_0_out_ready).
aud_bclk  out  1  I2S bit clock.
aud_daclrck  out  1  I2S word select; 0 = left.
aud_dacdat  out  1  I2S serial data.
frame_tick  out  1  one-cycle pulse at each frame boundary.
underflow  out  1  one-cycle pulse when a boundary finds no sample.
underflow_count  out  UNDERFLOW_CNT_W  saturating underflow total.

Behaviour:
- Reset values: in_ready 0, aud_bclk 0, aud_daclrck 1, aud_dacdat 0, frame_tick 0, underflow 0, underflow_count 0. Internal: hold_full 0, bit_cnt 63, state IDLE, vol_active 0, mute_active 1.
- Hold register: one 32-bit raw frame. in_ready = !hold_full, forced 0 while reset is high. A transfer (in_valid && in_ready) sets hold_full on the next edge. Accepting is allowed in IDLE.
- Divider: div_cnt counts 0..BCLK_HALF_DIV-1 in RUN. At terminal count aud_bclk toggles. BCLK falling edge = the cycle aud_bclk goes 1->0.
- bit_cnt (6-bit) increments on each BCLK falling edge. The wrap 63->0 is the frame boundary.
- States:
  - IDLE: aud_bclk 0, aud_daclrck 1, aud_dacdat 0, divider cleared. Goes to RUN when enable=1.
  - RUN: at each frame boundary with enable=0, returns to IDLE. bit_cnt stays 63 and no load occurs, so the last frame always completes.
- Frame boundary actions, all in the same cycle:
  - vol_active<=vol and mute_active<=mute.
  - frame_tick pulses.
  - If hold_full: shift register <= scale(hold) using the new vol/mute, and hold_full clears.
  - Else: shift register <= 0, underflow pulses, underflow_count increments (saturating at all-ones).
- aud_daclrck <= bit_cnt[5], updated on the BCLK falling edge.
- aud_dacdat on the falling edge with new bit_cnt = k:
  - k in 1..16: left bit 16-k (MSB first).
  - k in 33..48: right bit 48-k.
  - Otherwise 0. This gives the standard I2S one-BCLK MSB delay with 15 zero pad bits per slot.
- Scaling per channel: p = s16 * {0,vol} (signed 24-bit); r = p >>> 6 (arithmetic shift). Saturate r to [-32768, 32767]. mute_active forces 0.
- Latency: a word accepted before a boundary appears as the left MSB one BCLK after that boundary.
- Accept coincident with an empty boundary: the boundary records an underflow; the word enters hold and plays next frame.
- Reset mid-frame: immediate return to reset values; hold contents are discarded.
- vol/mute changes mid-frame: no effect until the next boundary.

Decomposition:
- Package audio_i2s_pkg: SAMPLE_W=16, VOL_W=7, SLOT_BITS=32, UNITY_SHIFT=6, SAT_MAX/SAT_MIN constants, state enum {IDLE, RUN}.
- Sub-module vol_scale_sat: combinational multiply/shift/saturate, instantiated twice (left, right).

Test Plan:
1. Reset, enable=0, in_valid=0 for 500 cycles -> aud_bclk 0, aud_daclrck 1, aud_dacdat 0, in_ready 1 after reset drops, underflow_count 0.
2. Frame and timing: vol=64, push 0x1234_8001, enable=1 -> BCLK period 16 clk, frame 1024 clk. Left slot bits 1..16 = 0x1234; right slot bits 33..48 = 0x8001; all pad bits 0.
3. Saturation: vol=127, push 0x6000_A000 -> left 0x7FFF, right 0x8000. Then vol=32, push 0x4000_C000 -> 0x2000, 0xE000.
4. Underflow: running with no pushes for 3 frames -> aud_dacdat 0 throughout, 3 underflow pulses, underflow_count=3. Preload counter near max -> saturates at 0xFFFF.
5. Timing of controls: change vol 64->16 at bit_cnt 40 -> current frame unaffected, next frame quartered. mute=1 -> next frame all zeros, hold still consumed.
6. Disable and reset: enable=0 at bit_cnt 20 -> frame completes, then IDLE with lrck 1 and bclk 0. Reset at bit_cnt 10 with hold_full -> all reset values next cycle, hold empty.

Source files
------------

// File: rtl/audio_i2s_pkg.sv
// Shared constants and types for the I2S audio transmit path.
// Sample/volume widths, saturation limits and the transmitter state encoding.
package audio_i2s_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int VOL_W       = 7;
  localparam int SLOT_BITS   = 32;
  localparam int UNITY_SHIFT = 6;
  localparam int PROD_W      = 24;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One stereo frame as delivered by the stream: left in the upper half.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } frame_t;

endpackage

// File: rtl/vol_scale_sat.sv
// Combinational per-channel gain: sample * vol / 64 with saturation to 16 bits.
// A set mute input forces the result to zero.
module vol_scale_sat
  import audio_i2s_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [VOL_W-1:0]    vol,
  input  logic                       mute,
  output logic signed [SAMPLE_W-1:0] scaled
);

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic                     in_range;

  assign sample_ext = {{(PROD_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
  assign gain_ext   = {{(PROD_W-VOL_W){1'b0}}, vol};
  assign prod       = sample_ext * gain_ext;
  assign shifted    = prod >>> UNITY_SHIFT;

  // The value fits in 16 bits exactly when every bit above the sign bit matches it.
  assign in_range = (shifted[PROD_W-1:SAMPLE_W-1] == '0) ||
                    (shifted[PROD_W-1:SAMPLE_W-1] == '1);

  // NOTE: always_comb assigns a default first so no path leaves scaled unassigned (no latch).
  always_comb begin
    scaled = shifted[SAMPLE_W-1:0];
    if (!in_range) begin
      scaled = shifted[PROD_W-1] ? SAT_MIN : SAT_MAX;
    end
    if (mute) begin
      scaled = '0;
    end
  end

endmodule

// File: rtl/audio_stream_i2s_tx.sv
// I2S master transmitter fed by a valid/ready audio stream, with per-frame
// volume/mute latching and a saturating underflow counter.
module audio_stream_i2s_tx
  import audio_i2s_pkg::*;
#(
  parameter int BCLK_HALF_DIV   = 8,
  parameter int UNDERFLOW_CNT_W = 16
) (
  input  logic                       clk_50,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [VOL_W-1:0]           vol,
  input  logic                       mute,
  input  logic                       in_valid,
  input  logic [2*SLOT_BITS/2-1:0]   in_data,
  output logic                       in_ready,
  output logic                       aud_bclk,
  output logic                       aud_daclrck,
  output logic                       aud_dacdat,
  output logic                       frame_tick,
  output logic                       underflow,
  output logic [UNDERFLOW_CNT_W-1:0] underflow_count
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF_DIV - 1);

  state_t                     state;
  logic                       hold_full;
  frame_t                     hold;
  frame_t                     out_raw;
  logic [7:0]                 div_cnt;
  logic [5:0]                 bit_cnt;
  logic [5:0]                 bit_nxt;
  logic [VOL_W-1:0]           vol_active;
  logic                       mute_active;
  logic signed [SAMPLE_W-1:0] scaled_l;
  logic signed [SAMPLE_W-1:0] scaled_r;
  logic signed [SAMPLE_W-1:0] slot_word;
  logic [4:0]                 slot_pos;
  logic                       dat_nxt;
  logic                       accept;
  logic                       div_tc;
  logic                       bclk_fall;

  assign in_ready  = !hold_full && !reset;
  assign accept    = in_valid && in_ready;
  assign div_tc    = (div_cnt == DIV_LAST);
  assign bclk_fall = (state == RUN) && div_tc && aud_bclk;
  assign bit_nxt   = bit_cnt + 6'd1;

  // The frame being played is kept raw and scaled with the gain latched at its boundary.
  vol_scale_sat u_scale_l (
    .sample (out_raw.left),
    .vol    (vol_active),
    .mute   (mute_active),
    .scaled (scaled_l)
  );

  vol_scale_sat u_scale_r (
    .sample (out_raw.right),
    .vol    (vol_active),
    .mute   (mute_active),
    .scaled (scaled_r)
  );

  // Slot positions 1..16 carry the word MSB first; the rest of each slot is zero pad.
  assign slot_pos  = bit_nxt[4:0];
  assign slot_word = bit_nxt[5] ? scaled_r : scaled_l;

  always_comb begin
    dat_nxt = 1'b0;
    if (slot_pos != 5'd0 && slot_pos <= 5'd16) begin
      dat_nxt = slot_word[4'(5'd16 - slot_pos)];
    end
  end

  // NOTE: the raw hold word is plain storage; only hold_full needs reset to discard it.
  always_ff @(posedge clk_50) begin
    if (accept) begin
      hold <= in_data;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state           <= IDLE;
      hold_full       <= 1'b0;
      out_raw         <= '0;
      div_cnt         <= '0;
      bit_cnt         <= 6'd63;
      vol_active      <= '0;
      mute_active     <= 1'b1;
      aud_bclk        <= 1'b0;
      aud_daclrck     <= 1'b1;
      aud_dacdat      <= 1'b0;
      frame_tick      <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      frame_tick <= 1'b0;
      underflow  <= 1'b0;
      if (accept) begin
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          aud_bclk    <= 1'b0;
          aud_daclrck <= 1'b1;
          aud_dacdat  <= 1'b0;
          div_cnt     <= '0;
          bit_cnt     <= 6'd63;
          if (enable) begin
            state <= RUN;
          end
        end

        RUN: begin
          div_cnt <= div_tc ? 8'd0 : div_cnt + 8'd1;
          if (div_tc) begin
            aud_bclk <= ~aud_bclk;
          end

          if (bclk_fall) begin
            if (bit_cnt == 6'd63 && !enable) begin
              // Stop only after the last slot has fully played; no new frame is loaded.
              state       <= IDLE;
              aud_daclrck <= 1'b1;
              aud_dacdat  <= 1'b0;
            end else begin
              bit_cnt     <= bit_nxt;
              aud_daclrck <= bit_nxt[5];
              aud_dacdat  <= dat_nxt;

              if (bit_cnt == 6'd63) begin
                vol_active  <= vol;
                mute_active <= mute;
                frame_tick  <= 1'b1;
                if (hold_full) begin
                  out_raw   <= hold;
                  hold_full <= 1'b0;
                end else begin
                  out_raw   <= '0;
                  underflow <= 1'b1;
                  if (underflow_count != '1) begin
                    underflow_count <= underflow_count + UNDERFLOW_CNT_W'(1);
                  end
                end
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_stream_i2s_tx.sv
// Directed bench for audio_stream_i2s_tx: frame timing, scaling/saturation,
// control latching, underflow counting, disable and mid-frame reset.
module tb_audio_stream_i2s_tx;

  localparam int CNT_W = 3;
  localparam logic [63:0] DATA_MASK = 64'h0001_FFFE_0001_FFFE;
  localparam logic [63:0] LRCK_EXP  = 64'hFFFF_FFFF_0000_0000;

  logic             clk_50;
  logic             reset;
  logic             enable;
  logic [6:0]       vol;
  logic             mute;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             aud_bclk;
  logic             aud_daclrck;
  logic             aud_dacdat;
  logic             frame_tick;
  logic             underflow;
  logic [CNT_W-1:0] underflow_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          tick_cyc;
  int          rise1_cyc;
  int          rise2_cyc;
  logic        uf_seen;
  logic [63:0] bits;
  logic [63:0] lr;

  audio_stream_i2s_tx #(
    .BCLK_HALF_DIV   (8),
    .UNDERFLOW_CNT_W (CNT_W)
  ) dut (
    .clk_50          (clk_50),
    .reset           (reset),
    .enable          (enable),
    .vol             (vol),
    .mute            (mute),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .aud_bclk        (aud_bclk),
    .aud_daclrck     (aud_daclrck),
    .aud_dacdat      (aud_dacdat),
    .frame_tick      (frame_tick),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    int b = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && b < 2000) begin
      @(negedge clk_50);
      b++;
    end
    check("push_ready", 64'(in_ready), 64'd1);
    @(negedge clk_50);
    in_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int b = 0;
    do begin
      @(negedge clk_50);
      b++;
    end while (!frame_tick && b < 1200);
    tick_cyc = cyc;
    uf_seen  = underflow;
    check("tick_seen", 64'(frame_tick), 64'd1);
  endtask

  // Samples aud_dacdat/aud_daclrck at each BCLK rise; bit k of bits is slot position k.
  task automatic capture(input int nbits, input int chg_idx, input logic [6:0] chg_vol,
                         input logic chg_mute, input logic chg_en);
    logic prev;
    int   k = 0;
    int   budget = 0;
    bits = '0;
    lr   = '0;
    prev = aud_bclk;
    while (k < nbits && budget < 1200) begin
      @(negedge clk_50);
      budget++;
      if (aud_bclk && !prev) begin
        bits[k] = aud_dacdat;
        lr[k]   = aud_daclrck;
        if (k == 1) rise1_cyc = cyc;
        if (k == 2) rise2_cyc = cyc;
        if (k == chg_idx) begin
          vol    = chg_vol;
          mute   = chg_mute;
          enable = chg_en;
        end
        k++;
      end
      prev = aud_bclk;
    end
    check("capture_len", 64'(k), 64'(nbits));
  endtask

  task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
    logic [15:0] l;
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      l[15-i] = bits[1+i];
      r[15-i] = bits[33+i];
    end
    check({tag, "_left"},  64'(l), 64'(el));
    check({tag, "_right"}, 64'(r), 64'(er));
    check({tag, "_pad"},   bits & ~DATA_MASK, 64'd0);
    check({tag, "_lrck"},  lr, LRCK_EXP);
  endtask

  initial begin
    int ticks;
    reset    = 1'b1;
    enable   = 1'b0;
    vol      = 7'd64;
    mute     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset and idle
    repeat (3) @(negedge clk_50);
    check("ready_in_reset", 64'(in_ready), 64'd0);
    reset = 1'b0;
    repeat (500) @(negedge clk_50);
    check("idle_bclk",  64'(aud_bclk),        64'd0);
    check("idle_lrck",  64'(aud_daclrck),     64'd1);
    check("idle_dat",   64'(aud_dacdat),      64'd0);
    check("idle_ready", 64'(in_ready),        64'd1);
    check("idle_ucnt",  64'(underflow_count), 64'd0);
    check("idle_tick",  64'(frame_tick),      64'd0);

    // Unity gain, frame timing
    push(32'h1234_8001);
    check("hold_full_idle", 64'(in_ready), 64'd0);
    enable = 1'b1;
    wait_tick();
    check("f1_no_uf", 64'(uf_seen), 64'd0);
    ticks = tick_cyc;
    push(32'h6000_A000);
    vol = 7'd127;
    capture(64, -1, 7'd0, 1'b0, 1'b1);
    check_frame("f1", 16'h1234, 16'h8001);
    check("bclk_period", 64'(rise2_cyc - rise1_cyc), 64'd16);

    // Saturation at vol 127, then half gain
    wait_tick();
    check("frame_period", 64'(tick_cyc - ticks), 64'd1024);
    push(32'h4000_C000);
    vol = 7'd32;
    capture(64, -1, 7'd0, 1'b0, 1'b1);
    check_frame("f2_sat", 16'h7FFF, 16'h8000);

    wait_tick();
    push(32'h2000_F000);
    vol = 7'd64;
    capture(64, -1, 7'd0, 1'b0, 1'b1);
    check_frame("f3_half", 16'h2000, 16'hE000);

    // Volume change mid-frame takes effect at the next boundary
    wait_tick();
    push(32'h2000_F000);
    capture(64, 40, 7'd16, 1'b0, 1'b1);
    check_frame("f4_unaffected", 16'h2000, 16'hF000);

    wait_tick();
    push(32'h7FFF_8000);
    capture(64, 10, 7'd16, 1'b1, 1'b1);
    check_frame("f5_quarter", 16'h0800, 16'hFC00);

    // Muted frame still consumes the hold word
    wait_tick();
    check("mute_no_uf", 64'(uf_seen), 64'd0);
    check("mute_hold_consumed", 64'(in_ready), 64'd1);
    capture(64, 5, 7'd64, 1'b0, 1'b1);
    check_frame("f6_mute", 16'h0000, 16'h0000);

    // Underflow frames, then counter saturation
    for (int i = 1; i <= 3; i++) begin
      wait_tick();
      check("uf_pulse", 64'(uf_seen), 64'd1);
      check("uf_count", 64'(underflow_count), 64'(i));
      capture(64, -1, 7'd0, 1'b0, 1'b1);
      check_frame("uf_frame", 16'h0000, 16'h0000);
    end
    for (int i = 4; i <= 8; i++) begin
      wait_tick();
      check("uf_count_sat", 64'(underflow_count), 64'((i > 7) ? 7 : i));
    end

    // Disable mid-frame: the frame completes, then idle
    push(32'h1111_2222);
    wait_tick();
    check("g_no_uf", 64'(uf_seen), 64'd0);
    capture(64, 20, 7'd64, 1'b0, 1'b0);
    check_frame("f_disable", 16'h1111, 16'h2222);
    ticks = 0;
    repeat (40) begin
      @(negedge clk_50);
      if (frame_tick) ticks++;
    end
    check("stop_no_tick", 64'(ticks),           64'd0);
    check("stop_bclk",    64'(aud_bclk),        64'd0);
    check("stop_lrck",    64'(aud_daclrck),     64'd1);
    check("stop_dat",     64'(aud_dacdat),      64'd0);
    check("stop_ucnt",    64'(underflow_count), 64'd7);

    // Reset mid-frame with a full hold register
    push(32'h5555_AAAA);
    enable = 1'b1;
    wait_tick();
    push(32'h7FFF_7FFF);
    check("rst_pre_hold_full", 64'(in_ready), 64'd0);
    capture(10, -1, 7'd0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk_50);
    check("rst_ready",     64'(in_ready),        64'd0);
    check("rst_bclk",      64'(aud_bclk),        64'd0);
    check("rst_lrck",      64'(aud_daclrck),     64'd1);
    check("rst_dat",       64'(aud_dacdat),      64'd0);
    check("rst_ucnt",      64'(underflow_count), 64'd0);
    check("rst_tick",      64'(frame_tick),      64'd0);
    check("rst_underflow", 64'(underflow),       64'd0);
    enable = 1'b0;
    reset  = 1'b0;
    @(negedge clk_50);
    check("rst_hold_discarded", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
